// File: rtl/vu_peak_meter.sv
// vu_peak_meter: peak-level meter with attack / hold / decay, registered LED
// bar and clip indicator. The sample-rate tick is edge-detected on clk_in.
// Optional build macro VU_DOT_MODE_EN: when defined the bar shows a single lit
// segment (the highest one above threshold) instead of a thermometer code.
//
// State is visible on state_dbg: 0 = IDLE, 1 = HOLD, 2 = DECAY.
// The inputs have no valid/ready handshake. A sample is consumed on the single
// clk_in cycle where tick_in is high and was low on the previous cycle.
module vu_peak_meter #(
  parameter int DATA_W      = 12,
  parameter int LED_NO      = 8,
  parameter int HOLD_TICKS  = 4800,
  parameter int DECAY_TICKS = 960
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              tick_in,
  input  logic [DATA_W-1:0] sample_in,
  output logic [DATA_W-2:0] level_out,
  output logic [LED_NO-1:0] led_bar,
  output logic              clip_out,
  output logic [1:0]        state_dbg
);

  localparam int LW   = DATA_W - 1;
  localparam int HW   = $clog2(HOLD_TICKS + 1);
  localparam int DW   = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
  localparam int STEP = (1 << (DATA_W - 1)) / LED_NO;

  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_TICKS);
  localparam logic [DW-1:0] DECAY_END = DW'(DECAY_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DECAY = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_tick_d;
  logic [LW-1:0]   r_level;
  logic [LW-1:0]   w_level_nxt;
  logic [HW-1:0]   r_hold_cnt;
  logic [HW-1:0]   w_hold_nxt;
  logic [DW-1:0]   r_decay_cnt;
  logic [DW-1:0]   w_decay_nxt;
  logic            r_clip;
  logic            w_clip_nxt;
  logic [HW-1:0]   r_clip_cnt;
  logic [HW-1:0]   w_clip_cnt_nxt;
  logic [LED_NO-1:0] r_led;
  logic [LED_NO-1:0] w_thermo;
  logic [LED_NO-1:0] w_led_nxt;

  logic              w_tick_rise;
  logic [DATA_W-1:0] w_abs;
  logic [LW-1:0]     w_mag;
  logic              w_full;
  logic              w_attack;
  logic [LW-1:0]     w_dec_step;
  logic [LW-1:0]     w_level_dec;

  assign w_tick_rise = tick_in & ~r_tick_d;

  // Absolute value; only the most negative code overflows into the top bit,
  // and that case saturates to the largest positive magnitude.
  assign w_abs  = sample_in[DATA_W-1] ? (~sample_in + 1'b1) : sample_in;
  assign w_mag  = w_abs[DATA_W-1] ? {LW{1'b1}} : w_abs[LW-1:0];
  assign w_full = (sample_in == {1'b0, {LW{1'b1}}}) ||
                  (sample_in == {1'b1, {LW{1'b0}}});

  assign w_attack    = (w_mag >= r_level);
  assign w_dec_step  = ((r_level >> 3) == '0) ? LW'(1) : (r_level >> 3);
  assign w_level_dec = (r_level > w_dec_step) ? (r_level - w_dec_step) : '0;

  // Peak FSM next-state: attack wins in every state, otherwise hold countdown
  // or periodic proportional decay, all gated by the tick strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    w_hold_nxt  = r_hold_cnt;
    w_decay_nxt = r_decay_cnt;
    if (w_tick_rise) begin
      if (w_attack) begin
        // A zero sample at zero level is an attack that changes nothing.
        if (w_mag != '0) begin
          w_level_nxt = w_mag;
          w_hold_nxt  = HOLD_INIT;
          w_state_nxt = ST_HOLD;
          w_decay_nxt = '0;
        end
      end else begin
        case (r_state)
          ST_HOLD: begin
            if (r_hold_cnt != '0) begin
              w_hold_nxt = r_hold_cnt - 1'b1;
            end
            if (r_hold_cnt <= HW'(1)) begin
              w_state_nxt = ST_DECAY;
              w_decay_nxt = '0;
            end
          end
          ST_DECAY: begin
            if (r_decay_cnt >= DECAY_END) begin
              w_decay_nxt = '0;
              w_level_nxt = w_level_dec;
              if (w_level_dec == '0) begin
                w_state_nxt = ST_IDLE;
              end
            end else begin
              w_decay_nxt = r_decay_cnt + 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Clip indicator: full-scale sample (re)loads the countdown, each other
  // tick counts it down and the flag drops when it hits zero.
  always_comb begin
    w_clip_nxt     = r_clip;
    w_clip_cnt_nxt = r_clip_cnt;
    if (w_tick_rise) begin
      if (w_full) begin
        w_clip_nxt     = 1'b1;
        w_clip_cnt_nxt = HOLD_INIT;
      end else if (r_clip_cnt != '0) begin
        w_clip_cnt_nxt = r_clip_cnt - 1'b1;
        if (r_clip_cnt == HW'(1)) begin
          w_clip_nxt = 1'b0;
        end
      end
    end
  end

  // Bar decode from the registered level; segment i lights when level > i*STEP.
  always_comb begin
    w_thermo = '0;
    for (int i = 0; i < LED_NO; i++) begin
      w_thermo[i] = (r_level > LW'(i * STEP));
    end
`ifdef VU_DOT_MODE_EN
    // Thermometer code is contiguous from bit 0, so its top bit is the dot.
    w_led_nxt = w_thermo & ~(w_thermo >> 1);
`else
    w_led_nxt = w_thermo;
`endif
  end

  // State and output registers; reset overrides everything.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_tick_d    <= 1'b1;
      r_state     <= ST_IDLE;
      r_level     <= '0;
      r_hold_cnt  <= '0;
      r_decay_cnt <= '0;
      r_clip      <= 1'b0;
      r_clip_cnt  <= '0;
      r_led       <= '0;
    end else begin
      r_tick_d    <= tick_in;
      r_state     <= w_state_nxt;
      r_level     <= w_level_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_decay_cnt <= w_decay_nxt;
      r_clip      <= w_clip_nxt;
      r_clip_cnt  <= w_clip_cnt_nxt;
      r_led       <= w_led_nxt;
    end
  end

  assign level_out = r_level;
  assign led_bar   = r_led;
  assign clip_out  = r_clip;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_vu_peak_meter.sv
// Bench for vu_peak_meter with short hold/decay (4 / 2 ticks). A spec-level
// model tracks level, hold/decay progress and clip countdown in plain ints and
// is compared against the DUT on every falling edge; directed literal checks
// pin the model to hand-computed values.
module tb_vu_peak_meter;

  localparam int DATA_W = 12;
  localparam int LED_NO = 8;
  localparam int HOLD   = 4;
  localparam int DECAY  = 2;

  logic              clk_in = 1'b0;
  logic              rst;
  logic              tick_in;
  logic [DATA_W-1:0] sample_in;
  logic [DATA_W-2:0] level_out;
  logic [LED_NO-1:0] led_bar;
  logic              clip_out;
  logic [1:0]        state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  vu_peak_meter #(
    .DATA_W(DATA_W), .LED_NO(LED_NO), .HOLD_TICKS(HOLD), .DECAY_TICKS(DECAY)
  ) dut (
    .clk_in(clk_in), .rst(rst), .tick_in(tick_in), .sample_in(sample_in),
    .level_out(level_out), .led_bar(led_bar), .clip_out(clip_out),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  // ---------------- checking helper ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_level, m_hold_left, m_decay_age, m_clip, m_clip_left, m_led;
  bit m_prev_tick;

  function automatic int mag_of(input logic [DATA_W-1:0] s);
    int v;
    v = int'($signed(s));
    if (v < 0) v = -v;
    if (v > 2047) v = 2047;
    return v;
  endfunction

  function automatic int bar_of(input int lvl);
    int b;
    int top;
    b = 0;
    top = -1;
    for (int i = 0; i < LED_NO; i++) begin
      if (lvl > i * 256) begin
        b = b | (1 << i);
        top = i;
      end
    end
`ifdef VU_DOT_MODE_EN
    b = (top < 0) ? 0 : (1 << top);
`endif
    return b;
  endfunction

  always @(posedge clk_in) begin
    int m, st;
    bit rise;
    if (rst) begin
      m_level = 0; m_hold_left = 0; m_decay_age = 0;
      m_clip = 0; m_clip_left = 0; m_led = 0; m_prev_tick = 1'b1;
    end else begin
      rise = tick_in && !m_prev_tick;
      m_prev_tick = tick_in;
      m_led = bar_of(m_level);
      if (rise) begin
        m = mag_of(sample_in);
        if (m >= m_level) begin
          if (m > 0) begin
            m_level = m; m_hold_left = HOLD; m_decay_age = 0;
          end
        end else if (m_hold_left > 0) begin
          m_hold_left--;
          if (m_hold_left == 0) m_decay_age = 0;
        end else if (m_level > 0) begin
          m_decay_age++;
          if (m_decay_age == DECAY) begin
            m_decay_age = 0;
            st = m_level / 8;
            if (st < 1) st = 1;
            m_level = (m_level > st) ? m_level - st : 0;
          end
        end
        if (sample_in == 12'h7FF || sample_in == 12'h800) begin
          m_clip = 1; m_clip_left = HOLD;
        end else if (m_clip_left > 0) begin
          m_clip_left--;
          if (m_clip_left == 0) m_clip = 0;
        end
      end
    end
  end

  // ---------------- scoreboard: every-cycle compare ----------------
  always @(negedge clk_in) begin
    if (cmp_en) begin
      chk("level_out", int'(level_out), m_level);
      chk("led_bar", int'(led_bar), m_led);
      chk("clip_out", int'(clip_out), m_clip);
    end
  end

  // ---------------- driver tasks ----------------
  // Called 1 time unit after a rising edge; the sample is captured on the
  // next rising edge. Leaves the bench 1 time unit after a rising edge.
  task automatic do_tick(input logic [DATA_W-1:0] s, input int high_cyc,
                         input bit wiggle);
    sample_in = s;
    tick_in   = 1'b1;
    for (int k = 0; k < high_cyc; k++) begin
      @(posedge clk_in); #1;
      if (wiggle) sample_in = DATA_W'($urandom_range(1000, 2000));
    end
    tick_in = 1'b0;
    repeat (2) begin @(posedge clk_in); #1; end
  endtask

  task automatic zero_ticks(input int n);
    for (int k = 0; k < n; k++) do_tick('0, 1, 1'b0);
  endtask

  int dot_1024, dot_2047, dot_1280, dot_256;

  initial begin
    int budget;
`ifdef VU_DOT_MODE_EN
    dot_1024 = 8'h08; dot_2047 = 8'h80; dot_1280 = 8'h10; dot_256 = 8'h01;
`else
    dot_1024 = 8'h0F; dot_2047 = 8'hFF; dot_1280 = 8'h1F; dot_256 = 8'h01;
`endif
    // Reset with tick already high.
    rst = 1'b1; tick_in = 1'b1; sample_in = 12'h400;
    repeat (2) begin @(posedge clk_in); #1; end
    cmp_en = 1'b1;
    chk("rst_level", int'(level_out), 0);
    chk("rst_led", int'(led_bar), 0);
    chk("rst_clip", int'(clip_out), 0);
    rst = 1'b0;
    repeat (3) begin @(posedge clk_in); #1; end
    chk("no_rise_after_rst", int'(level_out), 0);
    tick_in = 1'b0;
    @(posedge clk_in); #1;

    // Attack, hold, decay, retrigger.
    do_tick(12'h400, 1, 1'b0);
    chk("attack_level", int'(level_out), 1024);
    chk("attack_led", int'(led_bar), dot_1024);
    zero_ticks(HOLD);
    chk("held_level", int'(level_out), 1024);
    zero_ticks(2);
    chk("decay_896", int'(level_out), 896);
    zero_ticks(2);
    chk("decay_784", int'(level_out), 784);
    do_tick(12'h500, 1, 1'b0);
    chk("retrig_level", int'(level_out), 1280);
    chk("retrig_led", int'(led_bar), dot_1280);
    do_tick(12'd300, 1, 1'b0);
    chk("small_in_hold", int'(level_out), 1280);
    zero_ticks(HOLD - 1);
    chk("rehold_full", int'(level_out), 1280);
    zero_ticks(2);
    chk("decay_1120", int'(level_out), 1120);

    // Decay all the way down, bounded.
    budget = 400;
    while (level_out != '0 && budget > 0) begin
      zero_ticks(1);
      budget--;
    end
    chk("decay_to_zero_in_budget", int'(budget > 0), 1);
    chk("zero_level", int'(level_out), 0);
    chk("zero_led", int'(led_bar), 0);
    chk("idle_state", int'(state_dbg), 0);

    // Fresh 1024 decay series.
    do_tick(12'h400, 1, 1'b0);
    zero_ticks(HOLD + 2);
    chk("series_896", int'(level_out), 896);
    zero_ticks(2);
    chk("series_784", int'(level_out), 784);
    zero_ticks(2);
    chk("series_686", int'(level_out), 686);

    // Clip from most-negative code, then countdown and retrigger.
    do_tick(12'h800, 1, 1'b0);
    chk("clip_level", int'(level_out), 2047);
    chk("clip_led", int'(led_bar), dot_2047);
    chk("clip_set", int'(clip_out), 1);
    zero_ticks(HOLD - 1);
    chk("clip_still", int'(clip_out), 1);
    zero_ticks(1);
    chk("clip_clear", int'(clip_out), 0);
    do_tick(12'h7FF, 1, 1'b0);
    chk("clip_pos_fs", int'(clip_out), 1);
    zero_ticks(2);
    do_tick(12'h800, 1, 1'b0);
    zero_ticks(HOLD - 1);
    chk("clip_retrig", int'(clip_out), 1);
    zero_ticks(1);
    chk("clip_retrig_clear", int'(clip_out), 0);
    do_tick(12'h801, 1, 1'b0);
    chk("neg2047_level", int'(level_out), 2047);
    chk("neg2047_noclip", int'(clip_out), 0);

    // Reset mid-hold.
    rst = 1'b1;
    @(posedge clk_in); #1;
    chk("midrst_level", int'(level_out), 0);
    chk("midrst_led", int'(led_bar), 0);
    rst = 1'b0;
    @(posedge clk_in); #1;

    // Wide tick with a changing sample: one update with the rise-edge sample.
    do_tick(12'h100, 50, 1'b1);
    chk("wide_tick_level", int'(level_out), 256);
    chk("wide_tick_led", int'(led_bar), dot_256);
    repeat (4) begin @(posedge clk_in); #1; end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
